// File: rtl/jtag_ctrl_reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// jtag_ctrl_reg_bank_pkg
// Shared constants and helpers for the multi-channel JTAG control register bank:
// virtual IR opcodes, the address-width calculation and the IR class decode.
// -----------------------------------------------------------------------------
package jtag_ctrl_reg_bank_pkg;

  localparam logic [2:0] IR_BYPASS = 3'b000;
  localparam logic [2:0] IR_ADDR   = 3'b001;
  localparam logic [2:0] IR_WRITE  = 3'b010;
  localparam logic [2:0] IR_READ   = 3'b011;
  localparam logic [2:0] IR_STICKY = 3'b100;

  // Address width for n channels: ceil(log2(n)), never below 1 bit.
  function automatic int calc_aw(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Unassigned opcodes 101..111 behave exactly like BYPASS.
  function automatic logic is_bypass_class(input logic [2:0] ir);
    return !(ir inside {IR_ADDR, IR_WRITE, IR_READ, IR_STICKY});
  endfunction

endpackage

// File: rtl/jtag_ctrl_channel.sv
// -----------------------------------------------------------------------------
// jtag_ctrl_channel
// One channel of the register bank: a control register with optional
// self-clearing pulse bits, its pulse counter, and a sticky status latch.
//
// Ports:
//   clk, reset   - TAP clock, synchronous active-high reset
//   wr_en, wdata - load ctrl with wdata (pulse bits start a PULSE_LEN pulse)
//   clr_en       - write-1-to-clear the sticky latch using clr_mask
//   status       - live status; every set bit is OR-ed into the sticky latch
//   ctrl         - control register value
//   sticky       - sticky latch value
// -----------------------------------------------------------------------------
module jtag_ctrl_channel #(
  parameter int          DW         = 8,
  parameter logic [DW-1:0] RESET_VAL  = '0,
  parameter logic [DW-1:0] PULSE_MASK = '0,
  parameter int          PULSE_LEN  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wdata,
  input  logic          clr_en,
  input  logic [DW-1:0] clr_mask,
  input  logic [DW-1:0] status,
  output logic [DW-1:0] ctrl,
  output logic [DW-1:0] sticky
);

  logic [7:0] cnt;
  logic       pulse_load;

  assign pulse_load = wr_en && ((wdata & PULSE_MASK) != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl   <= RESET_VAL;
      cnt    <= '0;
      sticky <= '0;
    end else begin
      // The pulse bits are dropped on the edge where the counter leaves 1,
      // so a pulse bit reads 1 for exactly PULSE_LEN cycles. A write that
      // carries no pulse bits leaves the running counter alone.
      if (wr_en) begin
        ctrl <= wdata;
      end else if (cnt == 8'd1) begin
        ctrl <= ctrl & ~PULSE_MASK;
      end

      if (pulse_load) begin
        cnt <= 8'(PULSE_LEN);
      end else if (cnt != '0) begin
        cnt <= cnt - 8'd1;
      end

      // OR-ing status after the clear makes a same-cycle set win.
      sticky <= (clr_en ? (sticky & ~clr_mask) : sticky) | status;
    end
  end

endmodule

// File: rtl/jtag_ctrl_reg_bank.sv
// -----------------------------------------------------------------------------
// jtag_ctrl_reg_bank
// Multi-channel control/status register bank behind one virtual-JTAG TAP.
// Holds the IR, channel address, address error flag, DR shift buffer and the
// bypass bit; per-channel storage lives in jtag_ctrl_channel.
//
// Ports:
//   clk, reset          - TAP clock (tck), synchronous active-high reset
//   ir_in / ir_out      - virtual IR value in, combinational echo out
//   tdi / tdo           - serial data in / out (LSB first)
//   cdr, sdr, udr, uir  - capture-DR, shift-DR, update-DR, update-IR strobes
//   ctrl_out            - NCH control registers, channel c at [c*DW +: DW]
//   status_in           - NCH live status words, same packing
//   sticky_out          - NCH sticky latches, same packing
// -----------------------------------------------------------------------------
module jtag_ctrl_reg_bank
  import jtag_ctrl_reg_bank_pkg::*;
#(
  parameter int            DW         = 8,
  parameter int            NCH        = 4,
  parameter logic [DW-1:0] RESET_VAL  = '0,
  parameter logic [DW-1:0] PULSE_MASK = '0,
  parameter int            PULSE_LEN  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        ir_in,
  output logic [2:0]        ir_out,
  input  logic              tdi,
  output logic              tdo,
  input  logic              cdr,
  input  logic              sdr,
  input  logic              udr,
  input  logic              uir,
  output logic [NCH*DW-1:0] ctrl_out,
  input  logic [NCH*DW-1:0] status_in,
  output logic [NCH*DW-1:0] sticky_out
);

  localparam int AW = calc_aw(NCH);

  logic [2:0]    ir;
  logic          bypass_reg;
  logic [DW-1:0] shift_buf;
  logic [AW-1:0] addr;
  logic          err;

  logic          bypass_sel;
  logic          addr_ok;
  logic [DW-1:0] cap_val;

  logic [DW-1:0] ctrl_q   [NCH];
  logic [DW-1:0] sticky_q [NCH];
  logic [DW-1:0] status_w [NCH];

  assign ir_out     = ir_in;
  assign bypass_sel = is_bypass_class(ir);
  assign tdo        = bypass_sel ? bypass_reg : shift_buf[0];
  assign addr_ok    = int'(shift_buf[AW-1:0]) < NCH;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cap_val = '0;
    case (ir)
      IR_ADDR: begin
        cap_val[AW-1:0] = addr;
        if (DW > AW) cap_val[DW-1] = err;
      end
      IR_WRITE:  cap_val = ctrl_q[addr];
      IR_READ:   cap_val = status_w[addr];
      IR_STICKY: cap_val = sticky_q[addr];
      default:   cap_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir         <= IR_BYPASS;
      bypass_reg <= 1'b0;
      shift_buf  <= '0;
      addr       <= '0;
      err        <= 1'b0;
    end else begin
      if (uir) ir <= ir_in;
      bypass_reg <= tdi;

      // Strobe priority udr > cdr > sdr guards against illegal overlaps.
      if (udr) begin
        if (ir == IR_ADDR) begin
          if (addr_ok) begin
            addr <= shift_buf[AW-1:0];
            err  <= 1'b0;
          end else begin
            err  <= 1'b1;
          end
        end
      end else if (cdr) begin
        if (!bypass_sel) shift_buf <= cap_val;
      end else if (sdr) begin
        if (!bypass_sel) shift_buf <= {tdi, shift_buf[DW-1:1]};
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic sel;
    assign sel         = (int'(addr) == c);
    assign status_w[c] = status_in[c*DW +: DW];

    jtag_ctrl_channel #(
      .DW        (DW),
      .RESET_VAL (RESET_VAL),
      .PULSE_MASK(PULSE_MASK),
      .PULSE_LEN (PULSE_LEN)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (udr && (ir == IR_WRITE) && sel),
      .wdata   (shift_buf),
      .clr_en  (udr && (ir == IR_STICKY) && sel),
      .clr_mask(shift_buf),
      .status  (status_w[c]),
      .ctrl    (ctrl_q[c]),
      .sticky  (sticky_q[c])
    );

    assign ctrl_out[c*DW +: DW]   = ctrl_q[c];
    assign sticky_out[c*DW +: DW] = sticky_q[c];
  end

endmodule

// File: tb/tb_jtag_ctrl_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_jtag_ctrl_reg_bank
// Directed bench for jtag_ctrl_reg_bank (DW=8, NCH=3, RESET_VAL=8'h40,
// PULSE_MASK=8'h01, PULSE_LEN=4). A behavioural model tracks pulses as
// deadlines in absolute cycle numbers and is compared with the DUT after
// every clock edge; literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_jtag_ctrl_reg_bank;

  localparam int          DW   = 8;
  localparam int          NCH  = 3;
  localparam int          PLEN = 4;
  localparam logic [7:0]  RV   = 8'h40;
  localparam logic [7:0]  PM   = 8'h01;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [2:0]        ir_in = 3'b000;
  logic [2:0]        ir_out;
  logic              tdi = 1'b0;
  logic              tdo;
  logic              cdr = 1'b0, sdr = 1'b0, udr = 1'b0, uir = 1'b0;
  logic [NCH*DW-1:0] ctrl_out;
  logic [NCH*DW-1:0] status_in = '0;
  logic [NCH*DW-1:0] sticky_out;

  always #5 clk = ~clk;

  jtag_ctrl_reg_bank #(
    .DW(DW), .NCH(NCH), .RESET_VAL(RV), .PULSE_MASK(PM), .PULSE_LEN(PLEN)
  ) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .ir_out(ir_out),
    .tdi(tdi), .tdo(tdo), .cdr(cdr), .sdr(sdr), .udr(udr), .uir(uir),
    .ctrl_out(ctrl_out), .status_in(status_in), .sticky_out(sticky_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0] m_ir;
  logic       m_byp;
  logic [7:0] m_sb;
  int         m_addr;
  logic       m_err;
  logic [7:0] m_ctrl   [NCH];
  int         m_dead   [NCH];   // cycle number at which pulse bits vanish
  logic [7:0] m_sticky [NCH];
  int         cyc = 0;

  function automatic logic [7:0] vis(input int c);
    return (cyc < m_dead[c]) ? m_ctrl[c] : (m_ctrl[c] & ~PM);
  endfunction

  function automatic logic byp_class(input logic [2:0] v);
    return !(v inside {3'd1, 3'd2, 3'd3, 3'd4});
  endfunction

  task automatic model_step();
    logic [7:0] cap;
    logic [7:0] n_sb;
    int         n_cyc;
    n_cyc = cyc + 1;
    if (reset) begin
      m_ir = 3'b000; m_byp = 1'b0; m_sb = '0; m_addr = 0; m_err = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_ctrl[c] = RV; m_dead[c] = 0; m_sticky[c] = '0;
      end
      cyc = n_cyc;
      return;
    end
    case (m_ir)
      3'd1:    cap = 8'(m_addr) | (m_err ? 8'h80 : 8'h00);
      3'd2:    cap = vis(m_addr);
      3'd3:    cap = status_in[m_addr*8 +: 8];
      3'd4:    cap = m_sticky[m_addr];
      default: cap = 8'h00;
    endcase
    n_sb = m_sb;
    if (udr) n_sb = m_sb;
    else if (cdr && !byp_class(m_ir)) n_sb = cap;
    else if (sdr && !byp_class(m_ir)) n_sb = {tdi, m_sb[7:1]};
    for (int c = 0; c < NCH; c++) begin
      if (udr && m_ir == 3'd4 && c == m_addr) m_sticky[c] = m_sticky[c] & ~m_sb;
      m_sticky[c] = m_sticky[c] | status_in[c*8 +: 8];
    end
    // Retire a finished pulse into the stored value before any overwrite.
    for (int c = 0; c < NCH; c++) m_ctrl[c] = vis(c);
    if (udr && m_ir == 3'd2) begin
      m_ctrl[m_addr] = m_sb;
      if ((m_sb & PM) != 0) m_dead[m_addr] = n_cyc + PLEN;
    end
    if (udr && m_ir == 3'd1) begin
      if (int'(m_sb & 8'h03) < NCH) begin
        m_addr = int'(m_sb & 8'h03);
        m_err  = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (uir) m_ir = ir_in;
    m_byp = tdi;
    m_sb  = n_sb;
    cyc   = n_cyc;
  endtask

  task automatic compare();
    check("tdo", 64'(tdo), 64'(byp_class(m_ir) ? m_byp : m_sb[0]));
    check("ir_out", 64'(ir_out), 64'(ir_in));
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("ctrl%0d", c), 64'(ctrl_out[c*8 +: 8]), 64'(vis(c)));
      check($sformatf("sticky%0d", c), 64'(sticky_out[c*8 +: 8]), 64'(m_sticky[c]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // ---------------- TAP stimulus helpers ----------------
  task automatic set_ir(input logic [2:0] v);
    ir_in = v; uir = 1'b1; tick(); uir = 1'b0;
  endtask

  task automatic scan_shift(input logic [7:0] din, output logic [7:0] dout);
    cdr = 1'b1; tick(); cdr = 1'b0;
    sdr = 1'b1;
    for (int i = 0; i < DW; i++) begin
      dout[i] = tdo;
      tdi = din[i];
      tick();
    end
    sdr = 1'b0;
  endtask

  task automatic update();
    udr = 1'b1; tick(); udr = 1'b0;
  endtask

  task automatic scan(input logic [7:0] din, output logic [7:0] dout);
    scan_shift(din, dout);
    update();
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] got;
    logic [7:0] pat;
    int         cnt;

    tick(); tick();
    reset = 1'b0;
    check("rst_ctrl", 64'(ctrl_out), 64'({3{8'h40}}));
    check("rst_sticky", 64'(sticky_out), 64'h0);

    // Bypass: tdo replays tdi one cycle later.
    pat = 8'h4D;
    sdr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tdi = pat[i];
      tick();
      got[i] = tdo;
    end
    sdr = 1'b0; tdi = 1'b0;
    check("bypass_replay", 64'(got), 64'(pat));

    // Select channel 2 and write A5.
    set_ir(3'b001);
    scan(8'h02, d);
    check("addr_cap0", 64'(d), 64'h00);
    set_ir(3'b010);
    scan(8'hA5, d);
    check("wr_cap_rst", 64'(d), 64'h40);
    check("ch2_a5", 64'(ctrl_out[23:16]), 64'hA5);
    check("ch01_keep", 64'(ctrl_out[15:0]), 64'h4040);
    scan(8'hA5, d);
    check("rd_a5", 64'(d), 64'hA5);
    repeat (4) tick();
    check("ch2_pulse_gone", 64'(ctrl_out[23:16]), 64'hA4);

    // Out-of-range address sets err and holds addr; a valid one clears it.
    set_ir(3'b001);
    scan(8'h07, d);
    check("addr_cap2", 64'(d), 64'h02);
    scan(8'h01, d);
    check("addr_err_cap", 64'(d), 64'h82);
    scan(8'h00, d);
    check("addr_err_clr", 64'(d), 64'h01);

    // Pulse on ch0: bit0 for exactly 4 cycles, bit1 level.
    set_ir(3'b010);
    scan_shift(8'h03, d);
    update();
    cnt = int'(ctrl_out[0]);
    repeat (7) begin tick(); cnt += int'(ctrl_out[0]); end
    check("pulse_len", 64'(cnt), 64'd4);
    check("level_bit", 64'(ctrl_out[7:0]), 64'h02);
    // Rewrite two cycles into the pulse: 2 + 4 cycles high in total.
    update();
    cnt = int'(ctrl_out[0]);
    tick(); cnt += int'(ctrl_out[0]);
    update(); cnt += int'(ctrl_out[0]);
    repeat (7) begin tick(); cnt += int'(ctrl_out[0]); end
    check("pulse_restart", 64'(cnt), 64'd6);

    // Sticky: set by a one-cycle status pulse, cleared by W1C.
    status_in[11] = 1'b1; tick(); status_in[11] = 1'b0;
    tick(); tick();
    check("sticky_set", 64'(sticky_out[11]), 64'd1);
    set_ir(3'b001);
    scan(8'h01, d);
    set_ir(3'b100);
    scan(8'h08, d);
    check("sticky_cap", 64'(d), 64'h08);
    check("sticky_clr", 64'(sticky_out[15:8]), 64'h00);
    status_in[11] = 1'b1; tick(); status_in[11] = 1'b0; tick();
    scan_shift(8'h08, d);
    status_in[11] = 1'b1;
    update();
    status_in[11] = 1'b0;
    check("sticky_set_wins", 64'(sticky_out[11]), 64'd1);
    tick();
    check("sticky_hold", 64'(sticky_out[11]), 64'd1);

    // Live status readback from ch1.
    status_in[15:8] = 8'h5A;
    set_ir(3'b011);
    scan(8'h00, d);
    check("read_status", 64'(d), 64'h5A);
    status_in[15:8] = 8'h00;

    // Reset mid-shift with a ch0 pulse running.
    set_ir(3'b001);
    scan(8'h00, d);
    set_ir(3'b010);
    scan(8'h01, d);
    check("ch0_pulse_on", 64'(ctrl_out[7:0]), 64'h01);
    cdr = 1'b1; tick(); cdr = 1'b0;
    sdr = 1'b1; tdi = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("rst_mid_ctrl", 64'(ctrl_out), 64'({3{8'h40}}));
    check("rst_mid_tdo", 64'(tdo), 64'd0);
    reset = 1'b0; sdr = 1'b0; tdi = 1'b1;
    tick();
    check("rst_bypass_path", 64'(tdo), 64'd1);
    tdi = 1'b0;
    repeat (6) tick();
    check("pulse_aborted", 64'(ctrl_out), 64'({3{8'h40}}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
